// File: rtl/serial_frame_rx.sv
// Frame receiver for the same-clock serial link: start, 8 data bits MSB first, stop; byte lands in a one-entry valid/ready buffer 1 clk after the stop sample.
// A full buffer with rx_ready low drops the new byte (overrun pulse). `SERIAL_FRAME_RX_CNT_EN adds the frame_cnt output.
module serial_frame_rx #(
    parameter int BIT_PERIOD = 106,
    parameter int CNT_W      = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef SERIAL_FRAME_RX_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_PERIOD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             sample;
    logic             complete;
`ifdef SERIAL_FRAME_RX_CNT_EN
    logic [7:0]       fcnt_q, fcnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;
        sample   = (cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (!serial_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = 3'd7;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = serial_in;
                    if (idx_q == 3'd0) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end else if (!serial_in) begin
                    // A low between sample points is a broken line, not a new start bit.
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (sample) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    if (serial_in) begin
                        complete = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (!serial_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase

        // A drain on the completion cycle frees the slot for the new byte.
        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef SERIAL_FRAME_RX_CNT_EN
    always_comb begin
        fcnt_d = fcnt_q;
        if (complete) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame-level reference model plus directed and random frames.
module tb_serial_frame_rx;

    localparam int BP = 106;

    logic       clock;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef SERIAL_FRAME_RX_CNT_EN
    logic [7:0] frame_cnt;
`endif

    serial_frame_rx dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef SERIAL_FRAME_RX_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Current frame as scheduled by the driver: start edge, end edge, outcome.
    int         edge_n   = 0;
    int         fr_start = 0;
    int         fr_end   = -1;
    logic       fr_abort = 1'b0;
    logic [7:0] fr_byte  = 8'h00;

    // Expected DUT outputs after the most recent edge.
    logic       e_vld, e_ferr, e_ovr, e_busy;
    logic [7:0] e_data;
`ifdef SERIAL_FRAME_RX_CNT_EN
    logic [7:0] e_cnt;
`endif

    logic       rdy_rand, rdy_force, chk_en;
    int         n_chk = 0;
    int         n_err = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] xfer_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_loop();
        logic xfer;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                e_vld  = 1'b0;
                e_data = 8'h00;
                e_ferr = 1'b0;
                e_ovr  = 1'b0;
                e_busy = 1'b0;
`ifdef SERIAL_FRAME_RX_CNT_EN
                e_cnt  = 8'h00;
`endif
            end else begin
                edge_n++;
                xfer   = e_vld && rx_ready;
                e_ferr = 1'b0;
                e_ovr  = 1'b0;
                if (edge_n == fr_end && fr_end >= fr_start) begin
                    if (fr_abort) begin
                        e_ferr = 1'b1;
                    end else begin
`ifdef SERIAL_FRAME_RX_CNT_EN
                        e_cnt = e_cnt + 8'd1;
`endif
                        if (!e_vld || rx_ready) begin
                            e_data = fr_byte;
                            e_vld  = 1'b1;
                        end else begin
                            e_ovr = 1'b1;
                        end
                    end
                end else if (xfer) begin
                    e_vld = 1'b0;
                end
                e_busy = (edge_n >= fr_start) && (edge_n < fr_end);
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clock);
            #2;
            rx_ready = rdy_rand ? ($urandom_range(0, 2) == 0) : rdy_force;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("rx_valid", 32'(rx_valid), 32'(e_vld));
                chk("rx_data", 32'(rx_data), 32'(e_data));
                chk("frame_err", 32'(frame_err), 32'(e_ferr));
                chk("overrun", 32'(overrun), 32'(e_ovr));
                chk("busy", 32'(busy), 32'(e_busy));
`ifdef SERIAL_FRAME_RX_CNT_EN
                chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
`endif
                if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
                if (frame_err) ferr_cnt++;
                if (overrun) ovr_cnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called #1 after an edge; drives one frame starting on the next edge.
    task automatic send_frame(input logic [7:0] b, input int glitch, input int stop_at,
                              input bit bad_stop, input bit rdy_at_stop);
        int t0;
        t0       = edge_n + 1;
        fr_start = t0;
        fr_byte  = b;
        if (glitch >= 0) begin
            fr_end   = t0 + glitch;
            fr_abort = 1'b1;
        end else begin
            fr_end   = t0 + 9 * BP;
            fr_abort = bad_stop;
        end
        for (int i = 0; i <= 9 * BP; i++) begin
            if (i == stop_at || (glitch >= 0 && i == glitch + 1)) begin
                serial_in = 1'b1;
                return;
            end
            if (i == 0) serial_in = 1'b0;
            else if (i == glitch) serial_in = 1'b0;
            else if (i == 9 * BP) serial_in = !bad_stop;
            else if (i % BP == 0) serial_in = b[8 - i / BP];
            else serial_in = 1'b1;
            if (i == 9 * BP && rdy_at_stop) rdy_force = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int t0, lat, f0, o0, q0, g, kind;
        logic [7:0] b;
        reset_n   = 1'b0;
        serial_in = 1'b1;
        rx_ready  = 1'b0;
        rdy_force = 1'b0;
        rdy_rand  = 1'b0;
        chk_en    = 1'b0;
        fork
            model_loop();
            ready_loop();
            compare_loop();
        join_none
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_data", 32'(rx_data), 32'h0);
        idle(3);

        // Clean byte and its latency.
        rdy_force = 1'b1;
        idle(2);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        t0 = edge_n + 1;
        lat = -1;
        fork
            send_frame(8'hA5, -1, -1, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 2000; k++) begin
                    @(negedge clock);
                    if (rx_valid) begin
                        lat = edge_n + 1 - t0;
                        break;
                    end
                end
            end
        join
        chk("a5_latency", lat, 955);
        chk("a5_data", 32'(rx_data), 32'hA5);
        idle(5);
        chk("a5_no_ferr", ferr_cnt - f0, 0);
        chk("a5_no_ovr", ovr_cnt - o0, 0);

        // Back-to-back frames.
        q0 = xfer_q.size();
        f0 = ferr_cnt;
        send_frame(8'h00, -1, -1, 1'b0, 1'b0);
        send_frame(8'hFF, -1, -1, 1'b0, 1'b0);
        idle(5);
        chk("b2b_count", xfer_q.size() - q0, 2);
        chk("b2b_first", 32'(xfer_q[q0]), 32'h00);
        chk("b2b_second", 32'(xfer_q[q0+1]), 32'hFF);
        chk("b2b_no_ferr", ferr_cnt - f0, 0);

        // Glitch abort, then a clean retry.
        f0 = ferr_cnt;
        send_frame(8'h3C, 50, -1, 1'b0, 1'b0);
        idle(3);
        chk("glitch_ferr", ferr_cnt - f0, 1);
        chk("glitch_valid", 32'(rx_valid), 32'h0);
        chk("glitch_busy", 32'(busy), 32'h0);
        send_frame(8'h3C, -1, -1, 1'b0, 1'b0);
        chk("glitch_retry", 32'(rx_data), 32'h3C);
        idle(3);

        // Overrun with the consumer stalled.
        rdy_force = 1'b0;
        idle(3);
        send_frame(8'h11, -1, -1, 1'b0, 1'b0);
        idle(3);
        o0 = ovr_cnt;
        send_frame(8'h22, -1, -1, 1'b0, 1'b0);
        idle(3);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        q0 = xfer_q.size();
        rdy_force = 1'b1;
        idle(4);
        chk("ovr_drain_count", xfer_q.size() - q0, 1);
        chk("ovr_drain_byte", 32'(xfer_q[q0]), 32'h11);
        chk("ovr_drain_valid", 32'(rx_valid), 32'h0);

        // Drain and fill on the same edge.
        rdy_force = 1'b0;
        idle(2);
        send_frame(8'h11, -1, -1, 1'b0, 1'b0);
        idle(3);
        o0 = ovr_cnt;
        q0 = xfer_q.size();
        send_frame(8'h22, -1, -1, 1'b0, 1'b1);
        chk("sim_valid", 32'(rx_valid), 32'h1);
        chk("sim_data", 32'(rx_data), 32'h22);
        idle(4);
        chk("sim_xfer", 32'(xfer_q[q0]), 32'h11);
        chk("sim_no_ovr", ovr_cnt - o0, 0);

        // Asynchronous reset during bit 4.
        rdy_force = 1'b1;
        idle(3);
        send_frame(8'h5A, -1, 4 * BP + 30, 1'b0, 1'b0);
        chk("mid_busy", 32'(busy), 32'h1);
        #2;
        reset_n  = 1'b0;
        fr_start = 0;
        fr_end   = -1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_data", 32'(rx_data), 32'h0);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(3);
        send_frame(8'hC3, -1, -1, 1'b0, 1'b0);
        chk("post_rst_data", 32'(rx_data), 32'hC3);
`ifdef SERIAL_FRAME_RX_CNT_EN
        chk("post_rst_cnt", 32'(frame_cnt), 32'h1);
`endif
        idle(3);

        // Random frames against the model.
        rdy_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 19);
            g    = -1;
            if (kind < 3) begin
                g = $urandom_range(1, 9 * BP - 1);
                if (g % BP == 0) g++;
            end
            send_frame(b, g, -1, (kind >= 3 && kind < 6), 1'b0);
            idle($urandom_range(0, 4));
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receiver stage directly downstream of the ADC-sample serial transmitter; consumes its `data_out` line.
- That line idles high. Each frame bit is presented for exactly one clock, and consecutive bits are BIT_PERIOD clocks apart. Bit order: start (0), 8 data bits MSB first, stop (1).
- The block reconstructs each byte, checks line integrity between sample points, and hands the byte to a consumer through a one-entry valid/ready buffer.
- Same clock domain as the transmitter. No synchroniser and no oversampling.

Parameters:
- BIT_PERIOD, 106: clocks between consecutive bit presentations (transmitter delay 104 + 2). Legal range 2..1023.
- CNT_W, 10: width of the bit-period counter. Must hold BIT_PERIOD-1.

Ports:
- clock, input, 1: single clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- serial_in, input, 1: transmitter `data_out`.
- rx_data, output, 8: received byte. Stable while rx_valid=1.
- rx_valid, output, 1: buffer holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts. Transfer occurs when rx_valid && rx_ready.
- frame_err, output, 1: one-cycle pulse when a frame is aborted.
- overrun, output, 1: one-cycle pulse when a completed byte is dropped because the buffer is full.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0) drives all outputs to 0: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0. State returns to IDLE, counter=0, bit index=0.
- Reset mid-frame discards the partial byte and the buffered byte.
- States: IDLE, DATA, STOP.
- IDLE:
  - serial_in=0 at edge t0 is the start bit. Go to DATA with counter=0 and index=7.
  - serial_in=1 keeps the block in IDLE.
- Sample points: edges t0+k*BIT_PERIOD for k=1..9. k=1..8 are data bits (MSB first, index 7 down to 0). k=9 is the stop bit.
- Counter behaviour: increments each clock; reaching BIT_PERIOD-1 marks the next edge as a sample point, and the counter reloads to 0 on that sample.
- DATA:
  - On each sample point, shift register bit[index] <= serial_in and decrement index.
  - After index 0 is sampled, go to STOP.
- STOP:
  - At the stop sample point, serial_in must be 1.
  - Stop sample = 1: the frame completes and the block goes to IDLE.
  - Stop sample = 0: pulse frame_err, discard the byte, go to IDLE.
- Integrity rule: in DATA or STOP, serial_in=0 on any non-sample edge aborts the frame. Response: frame_err pulses the next cycle, the byte is discarded, and the block returns to IDLE. The offending 0 is not taken as a new start bit.
- Back-to-back frames: a start bit may arrive on the edge immediately after a stop sample. IDLE accepts it with no dead cycle.
- Completion (stop sample accepted at edge ts):
  - Buffer empty, or being drained the same cycle (rx_valid && rx_ready): rx_data <= byte and rx_valid=1 from ts+1. Latency is one clock after the stop sample.
  - Buffer full and rx_ready=0: byte dropped, rx_data unchanged, overrun pulses at ts+1.
- Buffer rules:
  - rx_valid stays high until a transfer.
  - A transfer with no simultaneous completion clears rx_valid next cycle.
  - rx_ready while rx_valid=0 has no effect.
- frame_err and overrun never assert in the same cycle from the same frame.
- busy=1 in DATA and STOP.

Optional Feature:
- Macro: SERIAL_FRAME_RX_CNT_EN.
- Defined:
  - Adds output port frame_cnt (8 bits, reset 0).
  - Increments on every successfully completed frame, including frames dropped by overrun. Does not increment on frame_err.
  - Wraps 255->0.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Clean byte: reset, then send 8'hA5 with BIT_PERIOD=106 and rx_ready=1 -> rx_valid rises exactly 9*106+1 clocks after the start edge, rx_data=8'hA5, frame_err=0, overrun=0.
- Back-to-back: send 8'h00 then 8'hFF with the start bit on the edge right after the stop sample -> two transfers, 8'h00 then 8'hFF, with no frame_err.
- Glitch abort: send 8'h3C but force serial_in=0 for one clock 50 clocks after the start edge -> frame_err pulses once, rx_valid stays 0, busy=0, next clean 8'h3C is received correctly.
- Overrun: hold rx_ready=0 and send 8'h11 then 8'h22 -> rx_data stays 8'h11, overrun pulses one cycle after the second stop sample. Then raise rx_ready -> one transfer of 8'h11, rx_valid falls.
- Simultaneous drain/fill: with 8'h11 buffered, assert rx_ready exactly on the cycle the 8'h22 stop sample completes -> 8'h11 transferred, rx_data=8'h22 next cycle, rx_valid stays 1, no overrun.
- Reset mid-frame: assert reset_n=0 asynchronously during bit 4 of 8'h5A -> outputs go to 0 immediately. After release, a new 8'hC3 is received correctly. With SERIAL_FRAME_RX_CNT_EN defined, frame_cnt=1 after 8'hC3.
